// File: rtl/collision_lives_ctrl_pkg.sv
// Shared game constants: FSM state encodings and default sprite geometry.
// Also consumed by car_ctrl, raccoon_ctrl and vga.
package collision_lives_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_GRACE = 2'd1,
    ST_DEAD  = 2'd2
  } life_state_e;

  localparam int DEF_COORD_W  = 10;
  localparam int DEF_PLAYER_W = 32;
  localparam int DEF_PLAYER_H = 32;
  localparam int DEF_OBJ_W    = 64;
  localparam int DEF_OBJ_H    = 32;

  // Width needed to index or count n items, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/collision_lives_ctrl_aabb.sv
// One combinational axis-aligned box compare between the player and an obstacle.
// Strict inequalities, sums widened by one bit so edge positions never wrap.
module aabb_overlap
  import collision_lives_ctrl_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int OBJ_W    = DEF_OBJ_W,
  parameter int OBJ_H    = DEF_OBJ_H
) (
  input  logic               i_Valid,
  input  logic [COORD_W-1:0] i_Px,
  input  logic [COORD_W-1:0] i_Py,
  input  logic [COORD_W-1:0] i_Ox,
  input  logic [COORD_W-1:0] i_Oy,
  output logic               o_Overlap
);

  localparam logic [COORD_W:0] PW_E = (COORD_W+1)'(PLAYER_W);
  localparam logic [COORD_W:0] PH_E = (COORD_W+1)'(PLAYER_H);
  localparam logic [COORD_W:0] OW_E = (COORD_W+1)'(OBJ_W);
  localparam logic [COORD_W:0] OH_E = (COORD_W+1)'(OBJ_H);

  logic [COORD_W:0] px_e, py_e, ox_e, oy_e;

  always_comb begin
    px_e = {1'b0, i_Px};
    py_e = {1'b0, i_Py};
    ox_e = {1'b0, i_Ox};
    oy_e = {1'b0, i_Oy};
    o_Overlap = i_Valid
              & (px_e < ox_e + OW_E) & (px_e + PW_E > ox_e)
              & (py_e < oy_e + OH_E) & (py_e + PH_E > oy_e);
  end

endmodule

// File: rtl/collision_lives_ctrl.sv
// Player-vs-N-obstacle collision arbiter with lives counter and post-hit grace window.
// Latency: overlap at inputs on cycle t -> registered ov at t+1 -> o_Hit at t+2.
module collision_lives_ctrl
  import collision_lives_ctrl_pkg::*;
#(
  parameter int  N_OBJ        = 3,
  parameter int  COORD_W      = DEF_COORD_W,
  parameter int  PLAYER_W     = DEF_PLAYER_W,
  parameter int  PLAYER_H     = DEF_PLAYER_H,
  parameter int  OBJ_W        = DEF_OBJ_W,
  parameter int  OBJ_H        = DEF_OBJ_H,
  parameter int  MAX_LIVES    = 3,
  parameter int  LIVES_W      = 4,
  parameter int  GRACE_CYCLES = 25000000,
  localparam int IDX_W        = min1_clog2(N_OBJ)
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic                       i_Restart,
  input  logic [COORD_W-1:0]         i_Player_X,
  input  logic [COORD_W-1:0]         i_Player_Y,
  input  logic [N_OBJ*COORD_W-1:0]   i_Obj_X,
  input  logic [N_OBJ*COORD_W-1:0]   i_Obj_Y,
  input  logic [N_OBJ-1:0]           i_Obj_Valid,
  output logic                       o_Overlap,
  output logic                       o_Hit,
  output logic [IDX_W-1:0]           o_Hit_Idx,
  output logic                       o_Respawn,
  output logic                       o_Invuln,
  output logic                       o_Game_Over,
  output logic [LIVES_W-1:0]         o_Lives,
  output logic [MAX_LIVES-1:0]       o_Life_LEDs
);

  localparam int                 CNT_W      = min1_clog2(GRACE_CYCLES);
  localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);

  if (MAX_LIVES >= 2**LIVES_W) begin : g_chk_lives
    $error("MAX_LIVES does not fit in LIVES_W");
  end
  if (GRACE_CYCLES < 1) begin : g_chk_grace
    $error("GRACE_CYCLES must be at least 1");
  end
  if (N_OBJ < 1) begin : g_chk_nobj
    $error("N_OBJ must be at least 1");
  end

  logic [N_OBJ-1:0] ov_d, ov_q;
  logic             overlap_d, overlap_q;

  for (genvar k = 0; k < N_OBJ; k++) begin : g_chan
    aabb_overlap #(
      .COORD_W (COORD_W),
      .PLAYER_W(PLAYER_W),
      .PLAYER_H(PLAYER_H),
      .OBJ_W   (OBJ_W),
      .OBJ_H   (OBJ_H)
    ) u_aabb (
      .i_Valid  (i_Obj_Valid[k]),
      .i_Px     (i_Player_X),
      .i_Py     (i_Player_Y),
      .i_Ox     (i_Obj_X[k*COORD_W +: COORD_W]),
      .i_Oy     (i_Obj_Y[k*COORD_W +: COORD_W]),
      .o_Overlap(ov_d[k])
    );
  end

  assign overlap_d = |ov_d;

  // Lowest index wins: scan downward so the last assignment is the smallest set bit.
  logic [IDX_W-1:0] win_idx;
  always_comb begin
    win_idx = '0;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (ov_q[k]) win_idx = IDX_W'(k);
    end
  end

  life_state_e           state_d, state_q;
  logic [LIVES_W-1:0]    lives_d, lives_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  hit_d, hit_q;
  logic                  respawn_d, respawn_q;
  logic [IDX_W-1:0]      hit_idx_d, hit_idx_q;
  logic [MAX_LIVES-1:0]  leds_d, leds_q;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    respawn_d = 1'b0;
    hit_idx_d = hit_idx_q;
    if (i_Restart) begin
      state_d = ST_GRACE;
      lives_d = LIVES_INIT;
      cnt_d   = GRACE_LOAD;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (i_Enable && (|ov_q)) begin
            hit_d     = 1'b1;
            hit_idx_d = win_idx;
            if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            if (lives_q <= LIVES_W'(1)) begin
              state_d = ST_DEAD;
            end else begin
              respawn_d = 1'b1;
              state_d   = ST_GRACE;
              cnt_d     = GRACE_LOAD;
            end
          end
        end
        ST_GRACE: begin
          if (i_Enable) begin
            if (cnt_q == '0) state_d = ST_ALIVE;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_DEAD: ;
        default: state_d = ST_ALIVE;
      endcase
    end
  end

  always_comb begin
    leds_d = '0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      leds_d[k] = (int'(lives_d) > k);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      ov_q      <= '0;
      overlap_q <= 1'b0;
      state_q   <= ST_ALIVE;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
      hit_idx_q <= '0;
      leds_q    <= '1;
    end else begin
      ov_q      <= ov_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
      hit_idx_q <= hit_idx_d;
      leds_q    <= leds_d;
    end
  end

  assign o_Overlap   = overlap_q;
  assign o_Hit       = hit_q;
  assign o_Hit_Idx   = hit_idx_q;
  assign o_Respawn   = respawn_q;
  assign o_Invuln    = (state_q == ST_GRACE);
  assign o_Game_Over = (state_q == ST_DEAD);
  assign o_Lives     = lives_q;
  assign o_Life_LEDs = leds_q;

endmodule

// File: tb/tb_collision_lives_ctrl.sv
// Directed bench for collision_lives_ctrl with a short grace window (4 cycles).
module tb_collision_lives_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        restart = 1'b0;
  logic [9:0]  px = 10'd100;
  logic [9:0]  py = 10'd100;
  logic [29:0] obj_x = '0;
  logic [29:0] obj_y = '0;
  logic [2:0]  obj_v = '0;
  logic        o_Overlap, o_Hit, o_Respawn, o_Invuln, o_Game_Over;
  logic [1:0]  o_Hit_Idx;
  logic [3:0]  o_Lives;
  logic [2:0]  o_Life_LEDs;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  collision_lives_ctrl #(.GRACE_CYCLES(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Restart(restart),
    .i_Player_X(px), .i_Player_Y(py),
    .i_Obj_X(obj_x), .i_Obj_Y(obj_y), .i_Obj_Valid(obj_v),
    .o_Overlap(o_Overlap), .o_Hit(o_Hit), .o_Hit_Idx(o_Hit_Idx),
    .o_Respawn(o_Respawn), .o_Invuln(o_Invuln), .o_Game_Over(o_Game_Over),
    .o_Lives(o_Lives), .o_Life_LEDs(o_Life_LEDs)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_obj(input int k, input int x, input int y, input logic v);
    obj_x[k*10 +: 10] = 10'(x);
    obj_y[k*10 +: 10] = 10'(y);
    obj_v[k] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; restart = 1'b0; obj_v = '0;
    px = 10'd100; py = 10'd100;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests_run++; if (o_Lives !== 4'd3) begin tests_failed++; $display("FAIL reset_lives: got %0d expected 3", o_Lives); end
    tests_run++; if (o_Life_LEDs !== 3'b111) begin tests_failed++; $display("FAIL reset_leds: got %b expected 111", o_Life_LEDs); end
    tests_run++; if ({o_Hit, o_Respawn, o_Invuln, o_Game_Over, o_Overlap} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {o_Hit, o_Respawn, o_Invuln, o_Game_Over, o_Overlap}); end
  endtask

  task automatic test_hit_grace();
    int n;
    do_reset();
    set_obj(1, 80, 100, 1'b1);
    step();
    tests_run++; if (o_Hit !== 1'b0 || o_Overlap !== 1'b1) begin tests_failed++; $display("FAIL hit_t1: hit %b ovl %b expected hit 0 ovl 1", o_Hit, o_Overlap); end
    step();
    tests_run++; if (o_Hit !== 1'b1 || o_Hit_Idx !== 2'd1 || o_Respawn !== 1'b1) begin tests_failed++; $display("FAIL hit_t2: hit %b idx %0d resp %b expected 1 1 1", o_Hit, o_Hit_Idx, o_Respawn); end
    tests_run++; if (o_Lives !== 4'd2 || o_Life_LEDs !== 3'b011) begin tests_failed++; $display("FAIL hit_lives: lives %0d leds %b expected 2 011", o_Lives, o_Life_LEDs); end
    obj_v = '0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!o_Invuln) break;
      n++;
      step();
    end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL grace_len: got %0d cycles expected 4", n); end
    tests_run++; if (o_Game_Over !== 1'b0 || o_Hit_Idx !== 2'd1 || o_Lives !== 4'd2) begin tests_failed++; $display("FAIL after_grace: go %b idx %0d lives %0d expected 0 1 2", o_Game_Over, o_Hit_Idx, o_Lives); end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    set_obj(1, 80, 100, 1'b1);
    step(); step();
    obj_v = '0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!o_Invuln) break;
      n++;
      if (i == 1) en = 1'b0;
      if (i == 4) en = 1'b1;
      step();
    end
    en = 1'b1;
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL pause_grace_len: got %0d cycles expected 7", n); end
  endtask

  task automatic test_edge_contact();
    do_reset();
    set_obj(0, 132, 100, 1'b1);
    step(); step();
    tests_run++; if (o_Overlap !== 1'b0 || o_Hit !== 1'b0) begin tests_failed++; $display("FAIL edge_touch: ovl %b hit %b expected 0 0", o_Overlap, o_Hit); end
    set_obj(0, 131, 100, 1'b1);
    step();
    tests_run++; if (o_Overlap !== 1'b1) begin tests_failed++; $display("FAIL edge_in_ovl: got %b expected 1", o_Overlap); end
    step();
    tests_run++; if (o_Hit !== 1'b1 || o_Hit_Idx !== 2'd0 || o_Lives !== 4'd2) begin tests_failed++; $display("FAIL edge_in_hit: hit %b idx %0d lives %0d expected 1 0 2", o_Hit, o_Hit_Idx, o_Lives); end
  endtask

  task automatic test_multi_hit();
    int hits;
    do_reset();
    set_obj(0, 90, 100, 1'b1);
    set_obj(2, 110, 110, 1'b1);
    step(); step();
    tests_run++; if (o_Hit !== 1'b1 || o_Hit_Idx !== 2'd0) begin tests_failed++; $display("FAIL multi_hit: hit %b idx %0d expected 1 0", o_Hit, o_Hit_Idx); end
    obj_v = '0;
    hits = 0;
    repeat (8) begin
      step();
      if (o_Hit) hits++;
    end
    tests_run++; if (hits !== 0 || o_Lives !== 4'd2) begin tests_failed++; $display("FAIL multi_single: extra hits %0d lives %0d expected 0 2", hits, o_Lives); end
  endtask

  task automatic test_game_over();
    int hits, resp;
    bit done;
    do_reset();
    set_obj(1, 100, 100, 1'b1);
    hits = 0; resp = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (o_Hit) hits++;
      if (o_Respawn) resp++;
      if (o_Game_Over) done = 1;
    end
    tests_run++; if (o_Game_Over !== 1'b1 || o_Lives !== 4'd0 || o_Life_LEDs !== 3'b000) begin tests_failed++; $display("FAIL game_over: go %b lives %0d leds %b expected 1 0 000", o_Game_Over, o_Lives, o_Life_LEDs); end
    tests_run++; if (o_Hit !== 1'b1 || o_Respawn !== 1'b0) begin tests_failed++; $display("FAIL final_hit: hit %b resp %b expected 1 0", o_Hit, o_Respawn); end
    tests_run++; if (hits !== 3 || resp !== 2) begin tests_failed++; $display("FAIL hit_count: hits %0d resp %0d expected 3 2", hits, resp); end
    hits = 0;
    repeat (10) begin
      step();
      if (o_Hit || o_Respawn) hits++;
    end
    tests_run++; if (hits !== 0 || o_Game_Over !== 1'b1 || o_Lives !== 4'd0) begin tests_failed++; $display("FAIL dead_hold: pulses %0d go %b lives %0d expected 0 1 0", hits, o_Game_Over, o_Lives); end
  endtask

  task automatic test_restart();
    int hits;
    // Continues from DEAD with the overlapping obstacle still present.
    restart = 1'b1;
    step();
    restart = 1'b0;
    tests_run++; if (o_Lives !== 4'd3 || o_Invuln !== 1'b1 || o_Game_Over !== 1'b0 || o_Life_LEDs !== 3'b111) begin tests_failed++; $display("FAIL restart: lives %0d inv %b go %b leds %b expected 3 1 0 111", o_Lives, o_Invuln, o_Game_Over, o_Life_LEDs); end
    hits = o_Hit ? 1 : 0;
    repeat (3) begin
      step();
      if (o_Hit) hits++;
    end
    tests_run++; if (hits !== 0 || o_Invuln !== 1'b1) begin tests_failed++; $display("FAIL spawn_protect: hits %0d inv %b expected 0 1", hits, o_Invuln); end
    hits = 0;
    repeat (2) begin
      step();
      if (o_Hit) hits++;
    end
    tests_run++; if (hits !== 1 || o_Lives !== 4'd2) begin tests_failed++; $display("FAIL post_spawn_hit: hits %0d lives %0d expected 1 2", hits, o_Lives); end
    // Restart arriving in the same cycle as an accepted hit.
    do_reset();
    set_obj(1, 100, 100, 1'b1);
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    tests_run++; if (o_Hit !== 1'b0 || o_Lives !== 4'd3 || o_Invuln !== 1'b1) begin tests_failed++; $display("FAIL restart_beats_hit: hit %b lives %0d inv %b expected 0 3 1", o_Hit, o_Lives, o_Invuln); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_obj(1, 80, 100, 1'b1);
    step(); step();
    tests_run++; if (o_Invuln !== 1'b1 || o_Lives !== 4'd2) begin tests_failed++; $display("FAIL pre_arst: inv %b lives %0d expected 1 2", o_Invuln, o_Lives); end
    #1 rst = 1'b1;
    #1;
    tests_run++; if (o_Invuln !== 1'b0 || o_Lives !== 4'd3 || o_Hit !== 1'b0) begin tests_failed++; $display("FAIL async_reset: inv %b lives %0d hit %b expected 0 3 0", o_Invuln, o_Lives, o_Hit); end
    step();
    obj_v = '0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit_grace();
    test_pause();
    test_edge_contact();
    test_multi_hit();
    test_game_over();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/collision_lives_ctrl.md
Name: collision_lives_ctrl

Overview:
- Parametrised successor to the fixed three-car collision logic and lives counter in the game top.
- Compares the player box against N obstacle boxes through a registered compare stage.
- Arbitrates simultaneous hits and manages lives with a post-hit invulnerability (grace) window.
- Drives game-over and respawn signals and a thermometer LED bar. Sits between raccoon_ctrl/car_ctrl and game_state.

Parameters:
- N_OBJ, 3, number of obstacle channels (1..16).
- COORD_W, 10, coordinate width.
- PLAYER_W, 32, player box width in pixels.
- PLAYER_H, 32, player box height in pixels.
- OBJ_W, 64, obstacle box width in pixels.
- OBJ_H, 32, obstacle box height in pixels.
- MAX_LIVES, 3, lives loaded at reset and restart.
- LIVES_W, 4, lives counter width.
- GRACE_CYCLES, 25000000, invulnerability length in i_Clk cycles.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Enable  in  1  game running; low pauses the block.
- i_Restart  in  1  synchronous single-cycle pulse: new game.
- i_Player_X  in  COORD_W  player top-left X.
- i_Player_Y  in  COORD_W  player top-left Y.
- i_Obj_X  in  N_OBJ*COORD_W  packed obstacle X; channel k occupies [k*COORD_W +: COORD_W].
- i_Obj_Y  in  N_OBJ*COORD_W  packed obstacle Y, same packing.
- i_Obj_Valid  in  N_OBJ  per-channel participate mask.
- o_Overlap  out  1  registered OR of all channel overlaps.
- o_Hit  out  1  one-cycle pulse on an accepted hit.
- o_Hit_Idx  out  IDX_W = max(1, clog2(N_OBJ))  channel of the last accepted hit.
- o_Respawn  out  1  one-cycle pulse when a hit leaves lives > 0.
- o_Invuln  out  1  high while in GRACE.
- o_Game_Over  out  1  high while in DEAD.
- o_Lives  out  LIVES_W  remaining lives.
- o_Life_LEDs  out  MAX_LIVES  thermometer: bit k = (o_Lives > k).

Behaviour:
- Reset (async, any time):
  - State ALIVE; o_Lives = MAX_LIVES; o_Life_LEDs all ones.
  - Overlap register, o_Hit, o_Hit_Idx, o_Respawn, o_Invuln, o_Game_Over and the grace counter all 0.
- Stage 1 (registered every cycle, regardless of i_Enable):
  - ov[k] = valid[k] & (px < ox+OBJ_W) & (px+PLAYER_W > ox) & (py < oy+OBJ_H) & (py+PLAYER_H > oy).
  - Sums computed at COORD_W+1 bits, so there is no wrap.
  - Inequalities are strict: touching edges are not a hit.
- Latency: an input overlap at cycle t gives ov at t+1 and o_Hit at t+2. All outputs are registered.
- Arbitration: when several ov bits are set, the lowest index wins. One hit costs exactly one life.
- FSM, states ALIVE, GRACE, DEAD:
  - ALIVE with i_Enable and |ov:
    - Pulse o_Hit, latch o_Hit_Idx, and decrement o_Lives.
    - If o_Lives was 1, go to DEAD with o_Game_Over=1 and no o_Respawn.
    - Otherwise pulse o_Respawn, go to GRACE, and load the counter with GRACE_CYCLES-1.
  - GRACE:
    - o_Invuln=1; ov is ignored.
    - Counter decrements only when i_Enable=1 (pause freezes it).
    - When the counter is 0 and i_Enable=1, go to ALIVE.
  - DEAD: all outputs hold; ov is ignored; only i_Restart or reset exit.
- i_Restart (any state):
  - o_Lives = MAX_LIVES, o_Game_Over = 0, go to GRACE with the counter at GRACE_CYCLES-1 (spawn protection).
  - Beats a same-cycle hit: no o_Hit, no decrement.
- i_Enable low: no hits are accepted; lives are held; the counter is frozen.
- o_Lives never underflows. o_Hit_Idx holds its value between hits.
- Elaboration checks: MAX_LIVES < 2**LIVES_W, GRACE_CYCLES >= 1, N_OBJ >= 1.

Decomposition:
- Shared game constants header:
  - FSM state encodings (ALIVE=2'd0, GRACE=2'd1, DEAD=2'd2).
  - Default PLAYER/OBJ dimensions and COORD_W, also used by car_ctrl, raccoon_ctrl and vga.
- Sub-module aabb_overlap: one combinational box-compare channel, instantiated N_OBJ times in a generate loop.
- The stage-1 register, priority encoder, FSM and counters stay in the top of this block.

Test Plan (GRACE_CYCLES=4, defaults otherwise):
1. Assert i_Reset, release -> o_Lives=3, o_Life_LEDs=3'b111; o_Hit, o_Respawn, o_Invuln and o_Game_Over all 0.
2. Player (100,100), obj1 (80,100) valid, i_Enable=1 ->
   - o_Hit exactly 2 cycles after the inputs; o_Hit_Idx=1; o_Respawn same cycle.
   - o_Lives=2, LEDs 3'b011, o_Invuln high 4 cycles, then ALIVE.
   - Dropping i_Enable for 3 cycles mid-GRACE extends o_Invuln by 3.
3. Edge contact: player X=100, obj0 X=132, same Y -> o_Overlap=0, no hit. Obj0 X=131 -> hit.
4. Objects on channels 0 and 2 overlap the player simultaneously -> single o_Hit, o_Hit_Idx=0, o_Lives decreases by exactly 1.
5. Three hits spaced beyond grace -> third hit:
   - o_Lives=0, o_Game_Over=1, no o_Respawn, LEDs 3'b000.
   - Sustained overlap afterwards causes no further pulses.
6. Recovery:
   - i_Restart while DEAD with overlap present -> o_Lives=3, o_Invuln=1, no hit for 4 cycles.
   - i_Reset asserted mid-GRACE -> o_Invuln=0 immediately, without waiting for a clock edge.
